tq_ret_ctl: RTL and testbench

TQ_RET_CTL -- requirements
Module: tq_ret_ctl

---
 rtl/tq_ret_ctl.sv | 157 +++++++++++++++
 tb/tb_tq_ret_ctl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tq_ret_ctl.sv
// Transform return-path controller: merges rows from the DCT and IDCT return
// paths into one registered row stream, tracks block progress and flags protocol errors.
module tq_ret_ctl #(
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_inverse,
  input  logic [1:0]        i_size,
  input  logic              i_valid0,
  input  logic [DATA_W-1:0] i_data0,
  input  logic              i_valid1,
  input  logic [DATA_W-1:0] i_data1,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [4:0]        o_row,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned CNT_W = 5;
  // Row total needs one bit more than the counter so that 32 is representable.
  localparam int unsigned N_W   = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                act_valid;
  logic                inact_valid;
  logic [DATA_W-1:0]   act_data;
  logic                last_row;
  logic                err_event;

  // Path selection by the latched block direction.
  always_comb begin
    act_valid   = 1'b0;
    inact_valid = 1'b0;
    act_data    = i_data0;
    if (mode_q) begin
      act_valid   = i_valid1;
      inact_valid = i_valid0;
      act_data    = i_data1;
    end else begin
      act_valid   = i_valid0;
      inact_valid = i_valid1;
      act_data    = i_data0;
    end
  end

  assign last_row = (cnt_q == CNT_W'(n_q - N_W'(1)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    data_d    = data_q;
    row_d     = row_q;
    err_d     = err_q;
    err_event = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid0 || i_valid1) begin
          err_event = 1'b1;
        end
        if (i_start) begin
          mode_d  = i_inverse;
          n_d     = N_W'(4) << i_size;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A start here never reopens the block, even alongside the last row.
        if (inact_valid || i_start) begin
          err_event = 1'b1;
        end
        if (act_valid) begin
          valid_d = 1'b1;
          data_d  = act_data;
          row_d   = cnt_q;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_row) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A simultaneous error wins over the clear from an accepted start.
    if (err_event) begin
      err_d = 1'b1;
    end
  end

  assign busy_d = (state_d == ST_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      n_q     <= N_W'(4);
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      row_q   <= row_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_row   = row_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_tq_ret_ctl.sv
// Self-checking bench for tq_ret_ctl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural block model.
module tb_tq_ret_ctl;

  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, inv, v0, v1;
  logic [1:0]    sz;
  logic [DW-1:0] d0, d1;
  logic          ov, odone, obusy, oerr;
  logic [DW-1:0] od;
  logic [4:0]    orow;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  bit            m_busy, m_mode;
  int            m_n, m_cnt;
  bit            e_valid, e_done, e_err;
  logic [DW-1:0] e_data;
  int            e_row;

  typedef struct {
    bit       st;
    bit       iv;
    bit [1:0] sz;
    bit       v0;
    bit       v1;
    bit       ev;
    int       erow;
    bit       edone;
    bit       ebusy;
    bit       eerr;
    int       dsel;   // 0: expect d0 of entry, 1: d1 of entry, 2: not checked
  } vec_t;

  vec_t tbl[28];

  always #5 clk = ~clk;

  tq_ret_ctl #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (start),
    .i_inverse(inv),
    .i_size   (sz),
    .i_valid0 (v0),
    .i_data0  (d0),
    .i_valid1 (v1),
    .i_data1  (d1),
    .o_valid  (ov),
    .o_data   (od),
    .o_row    (orow),
    .o_done   (odone),
    .o_busy   (obusy),
    .o_err    (oerr)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_mode = 0; m_n = 4; m_cnt = 0;
    e_valid = 0; e_data = '0; e_row = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit err_ev, av, iv;
    err_ev  = 0;
    e_valid = 0;
    e_done  = 0;
    if (!m_busy) begin
      if (v0 || v1) err_ev = 1;
      if (start) begin
        m_mode = inv; m_n = 4 << sz; m_cnt = 0; m_busy = 1; e_err = 0;
      end
    end else begin
      av = m_mode ? v1 : v0;
      iv = m_mode ? v0 : v1;
      if (iv || start) err_ev = 1;
      if (av) begin
        e_valid = 1;
        e_data  = m_mode ? d1 : d0;
        e_row   = m_cnt;
        e_done  = (m_cnt == m_n - 1);
        m_cnt++;
        if (e_done) m_busy = 0;
      end
    end
    if (err_ev) e_err = 1;
  endtask

  task automatic compare_model();
    chk("m_valid", DW'(ov),    DW'(e_valid));
    chk("m_data",  od,         e_data);
    chk("m_row",   DW'(orow),  DW'(e_row));
    chk("m_done",  DW'(odone), DW'(e_done));
    chk("m_busy",  DW'(obusy), DW'(m_busy));
    chk("m_err",   DW'(oerr),  DW'(e_err));
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked 1ns later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    start = 0; inv = 0; sz = 0; v0 = 0; v1 = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, DW'(ov),    '0);
    chk({nm, "_data"},  od,         '0);
    chk({nm, "_row"},   DW'(orow),  '0);
    chk({nm, "_done"},  DW'(odone), '0);
    chk({nm, "_busy"},  DW'(obusy), '0);
    chk({nm, "_err"},   DW'(oerr),  '0);
  endtask

  function automatic logic [DW-1:0] pat(input int idx, input int path);
    logic [DW-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'(idx) ^ (path != 0 ? 32'h1D1D_0000 : 32'h0D0D_0000) ^ 32'(w << 8);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mk(bit st, bit iv, bit [1:0] s, bit a, bit b,
                              bit ev, int erow, bit edone, bit ebusy, bit eerr, int dsel);
    vec_t v;
    v.st = st; v.iv = iv; v.sz = s; v.v0 = a; v.v1 = b;
    v.ev = ev; v.erow = erow; v.edone = edone; v.ebusy = ebusy; v.eerr = eerr; v.dsel = dsel;
    return v;
  endfunction

  initial begin
    int seen;
    // Forward 4x4, four back-to-back rows.
    tbl[0]  = mk(1,0,0, 0,0,  0,0,0,1,0, 2);
    tbl[1]  = mk(0,0,0, 1,0,  1,0,0,1,0, 0);
    tbl[2]  = mk(0,0,0, 1,0,  1,1,0,1,0, 0);
    tbl[3]  = mk(0,0,0, 1,0,  1,2,0,1,0, 0);
    tbl[4]  = mk(0,0,0, 1,0,  1,3,1,0,0, 0);
    tbl[5]  = mk(0,0,0, 0,0,  0,3,0,0,0, 2);
    // Forward 8x8 with a stray idct valid alongside row 2.
    tbl[6]  = mk(1,0,1, 0,0,  0,3,0,1,0, 2);
    tbl[7]  = mk(0,0,0, 1,0,  1,0,0,1,0, 0);
    tbl[8]  = mk(0,0,0, 1,0,  1,1,0,1,0, 0);
    tbl[9]  = mk(0,0,0, 1,1,  1,2,0,1,1, 0);
    tbl[10] = mk(0,0,0, 1,0,  1,3,0,1,1, 0);
    tbl[11] = mk(0,0,0, 1,0,  1,4,0,1,1, 0);
    tbl[12] = mk(0,0,0, 1,0,  1,5,0,1,1, 0);
    tbl[13] = mk(0,0,0, 1,0,  1,6,0,1,1, 0);
    tbl[14] = mk(0,0,0, 1,0,  1,7,1,0,1, 0);
    tbl[15] = mk(0,0,0, 0,0,  0,7,0,0,1, 2);
    // Inverse 4x4 clears the error; then idle valid and start-while-busy.
    tbl[16] = mk(1,1,0, 0,0,  0,7,0,1,0, 2);
    tbl[17] = mk(0,0,0, 0,1,  1,0,0,1,0, 1);
    tbl[18] = mk(0,0,0, 0,1,  1,1,0,1,0, 1);
    tbl[19] = mk(0,0,0, 0,1,  1,2,0,1,0, 1);
    tbl[20] = mk(0,0,0, 0,1,  1,3,1,0,0, 1);
    tbl[21] = mk(0,0,0, 1,0,  0,3,0,0,1, 2);
    tbl[22] = mk(1,0,0, 0,0,  0,3,0,1,0, 2);
    tbl[23] = mk(0,0,0, 1,0,  1,0,0,1,0, 0);
    tbl[24] = mk(1,1,3, 0,0,  0,0,0,1,1, 2);
    tbl[25] = mk(0,0,0, 1,0,  1,1,0,1,1, 0);
    tbl[26] = mk(0,0,0, 1,0,  1,2,0,1,1, 0);
    tbl[27] = mk(1,0,2, 1,0,  1,3,1,0,1, 0);

    idle_inputs();
    d0 = '0; d1 = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_zero("reset");
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      start = tbl[i].st; inv = tbl[i].iv; sz = tbl[i].sz;
      v0 = tbl[i].v0; v1 = tbl[i].v1;
      d0 = pat(i, 0); d1 = pat(i, 1);
      step();
      chk($sformatf("t%0d_valid", i), DW'(ov),    DW'(tbl[i].ev));
      chk($sformatf("t%0d_row", i),   DW'(orow),  DW'(tbl[i].erow));
      chk($sformatf("t%0d_done", i),  DW'(odone), DW'(tbl[i].edone));
      chk($sformatf("t%0d_busy", i),  DW'(obusy), DW'(tbl[i].ebusy));
      chk($sformatf("t%0d_err", i),   DW'(oerr),  DW'(tbl[i].eerr));
      if (tbl[i].dsel != 2) chk($sformatf("t%0d_data", i), od, pat(i, tbl[i].dsel));
    end
    idle_inputs();
    step();

    // Inverse 32x32 with random gaps.
    start = 1; inv = 1; sz = 3;
    step();
    idle_inputs();
    seen = 0;
    for (int c = 0; c < 400 && seen < 32; c++) begin
      v1 = ($urandom_range(0, 2) != 0);
      d1 = rnd_word();
      step();
      if (ov) begin
        chk("r32_row", DW'(orow), DW'(seen));
        chk("r32_done", DW'(odone), DW'(seen == 31));
        seen++;
      end
    end
    idle_inputs();
    chk("r32_count", DW'(seen), DW'(32));
    chk("r32_err", DW'(oerr), '0);
    step();
    chk("r32_idle", DW'(obusy), '0);

    // Abort a forward 16x16 after row 5 with reset.
    start = 1; sz = 2;
    step();
    idle_inputs();
    for (int r = 0; r < 6; r++) begin
      v0 = 1; d0 = rnd_word();
      step();
      chk("ab_row", DW'(orow), DW'(r));
    end
    v0 = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_zero("ab_rst");
    v0 = 1;
    step();
    chk_zero("ab_rst_hold");
    step();
    rst_n = 1'b1;
    step();
    chk("ab_post_valid", DW'(ov), '0);
    chk("ab_post_done", DW'(odone), '0);
    chk("ab_post_err", DW'(oerr), DW'(1));
    v0 = 0; start = 1; sz = 0;
    step();
    start = 0;
    for (int r = 0; r < 4; r++) begin
      v0 = 1; d0 = rnd_word();
      step();
      chk("ab_new_row", DW'(orow), DW'(r));
      chk("ab_new_done", DW'(odone), DW'(r == 3));
    end
    idle_inputs();
    step();

    // Randomized traffic including stray valids, late starts and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        step();
        rst_n = 1'b1;
      end
      inv = $urandom_range(0, 1);
      sz  = 2'($urandom_range(0, 3));
      d0  = rnd_word();
      d1  = rnd_word();
      if (m_busy) begin
        start = ($urandom_range(0, 99) < 2);
        v0 = m_mode ? ($urandom_range(0, 99) < 4) : ($urandom_range(0, 99) < 60);
        v1 = m_mode ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 4);
      end else begin
        start = ($urandom_range(0, 99) < 25);
        v0 = ($urandom_range(0, 99) < 3);
        v1 = ($urandom_range(0, 99) < 3);
      end
      step();
    end
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
